uart_rx: RTL
============

# uart_rx

UART receiver that deserialises an asynchronous 8N1 serial line using the 16x oversampling tick produced by the baud generator. It sits directly downstream of the baud generator, which it shares a clock with. It synchronises the raw `rx` pin, finds the start bit, and samples each bit at its midpoint. It then presents each received byte with a one-cycle done strobe and a framing-error flag.

## Interface
- `DBIT`, default 8: data bits per frame. Legal range 5..8. Bits are sent LSB first.
- `SB_TICK`, default 16: oversample ticks in the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- `clk` input, 1 bit: system clock, 100 MHz. All state changes on the rising edge.
- `resetn` input, 1 bit: reset, asynchronous and active-low.
- `baud_tick` input, 1 bit: 16x oversample strobe. It is one `clk` wide, and the block counts every cycle in which it is high.
- `rx` input, 1 bit: raw serial line, asynchronous. Idle level is 1.
- `rx_data` output, DBIT bits: last received byte. Held until the next frame completes.
- `rx_done_tick` output, 1 bit: one-cycle pulse when `rx_data` and `frame_err` update.
- `frame_err` output, 1 bit: 1 if the stop bit of the last frame sampled 0. Held until the next frame completes.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- Input synchroniser:
  - `rx` passes through 2 flip-flops, both reset to 1, giving `rx_s`. The FSM uses only `rx_s`.
- Registers:
  - `state` holds IDLE, START, DATA or STOP.
  - `s_cnt` is a 5-bit oversample counter.
  - `n_cnt` is a 3-bit bit counter.
  - `shreg` is a DBIT-bit shift register.
- IDLE:
  - `rx_s`==0 moves to START and clears `s_cnt`.
  - This transition does not depend on `baud_tick`.
- START: on each `baud_tick`:
  - If `s_cnt`==7 (mid start bit) and `rx_s`==0: move to DATA, clear `s_cnt` and `n_cnt`.
  - If `s_cnt`==7 and `rx_s`==1: treat it as a glitch. Return to IDLE with no strobe and outputs unchanged.
  - Otherwise increment `s_cnt`.
- DATA: on each `baud_tick`:
  - If `s_cnt`==15: clear `s_cnt` and shift in with `shreg` <= {`rx_s`, `shreg`[DBIT-1:1]}.
  - On that sample, if `n_cnt`==DBIT-1 move to STOP; otherwise increment `n_cnt`.
  - If `s_cnt`!=15, increment `s_cnt`.
- STOP: on each `baud_tick`:
  - If `s_cnt`==SB_TICK-1: return to IDLE and clear `s_cnt`.
  - In the same edge: `rx_data`<=`shreg`, `frame_err`<=~`rx_s`, `rx_done_tick`<=1.
  - Otherwise increment `s_cnt`.
- Framing errors: the data is still delivered and the flag is set. There is no resynchronisation beyond returning to IDLE. A line held low re-enters START immediately.
- Cycles with `baud_tick` low leave every counter unchanged.

## Timing
- Reset values:
  - `state`=IDLE, `s_cnt`=0, `n_cnt`=0, `shreg`=0.
  - `rx_data`=0, `rx_done_tick`=0, `frame_err`=0, `busy`=0.
  - Both synchroniser flops reset to 1.
- Reset mid-frame: asynchronous; all of the above take their reset values immediately. The partial frame is discarded and no strobe is issued.
- Edge detection: 2 `clk` of synchroniser latency, then 1 edge for IDLE->START. `busy` rises 3 `clk` after `rx` falls.
- Sample points (0-based ticks counted after START entry):
  - Start bit at tick 7.
  - Data bit k at tick 7+16(k+1).
  - Stop bit at tick 7+16·DBIT+SB_TICK.
- Done strobe:
  - `rx_done_tick` is high for exactly the one `clk` after the edge that samples the stop bit.
  - `busy` falls on that same edge.
- Back-to-back frames:
  - A start edge arriving in the same cycle that STOP exits is seen in IDLE on the next cycle.
  - No byte is lost as long as the sender idles at least 0 bits between frames.
- `baud_tick` asserted on consecutive cycles: each cycle counts as one tick. No edge filtering.

## Test plan
- Send 0x55 at 115200 (divisor 0x036, 54 clk/tick), 1 stop bit -> `rx_done_tick` pulses once, 1 clk wide; `rx_data`=0x55; `frame_err`=0.
- Send 0x00, then 0xFF, then 0xA3 back-to-back at 9600 (0x28B) -> three strobes with `rx_data` 0x00, 0xFF, 0xA3 in order; `frame_err`=0 each time.
- `rx` low for 4 ticks (~216 clk at 115200), then high -> FSM returns to IDLE at start tick 7; no strobe; `rx_data` unchanged; `busy` 1->0.
- Send 0x3C with the stop bit driven 0 -> strobe fires with `rx_data`=0x3C and `frame_err`=1. The next good frame 0xC3 clears `frame_err` to 0.
- Assert `resetn`=0 during data bit 4 of 0x96, release, then send 0x69 -> all outputs 0 during reset; no strobe for 0x96; next strobe gives `rx_data`=0x69.
- DBIT=7, SB_TICK=32: send 0x5A (7-bit) -> `rx_data`=7'h5A; strobe occurs 7+16·7+32 ticks after START entry.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversample tick. It synchronises rx, locks onto the
// start bit, samples each bit mid-period and strobes out each byte with a framing flag.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            baud_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [2:0] LAST_BIT  = 3'(DBIT - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);

    logic            sync1_q, sync2_q;
    logic            rx_s;
    logic [1:0]      state_q, state_d;
    logic [4:0]      s_cnt_q, s_cnt_d;
    logic [2:0]      n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_cnt_d     = n_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // Start detection is tick-independent so a start edge is never missed.
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (s_cnt_q == 5'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (s_cnt_q == 5'd15) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                if (baud_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        state_d     = IDLE;
                        s_cnt_d     = '0;
                        rx_data_d   = shreg_q;
                        frame_err_d = ~rx_s;
                        done_d      = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
        endcase
    end

    assign rx_data      = rx_data_q;
    assign frame_err    = frame_err_q;
    assign rx_done_tick = done_q;
    assign busy         = (state_q != IDLE);

endmodule
